adc_chan_capture: RTL and testbench
===================================

Name: adc_chan_capture

Overview:
- Per-channel ADC front-end stage, directly upstream of the FONT5_base processing core, in the clk357 domain.
- Removes the board-specific ADC bit-inversion mask and presents corrected two's-complement samples to the core.
- On a store strobe, captures a programmable window of corrected samples into an internal buffer after a programmable delay.
- Streams the captured window out over a valid/ready interface for readout to the RS-232 path.

Parameters:
- WIDTH, 13, ADC sample width in bits.
- BITFLIP, 13'h0000, per-channel XOR mask undoing ADC line inversions; signedness correction is folded in.
- DEPTH, 164, buffer depth in samples.
- ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W >= DEPTH.
- DLY_W, 7, width of the trigger-delay count.

Ports:
- clk357  in  1  357 MHz sample clock.
- rst  in  1  asynchronous active-high reset.
- data_in  in  WIDTH  raw delayed ADC bus (ch*_data_in_del).
- data_out  out  WIDTH  corrected signed sample to the core.
- store_strb  in  1  capture trigger; single-cycle pulse.
- trig_delay  in  DLY_W  clk357 cycles from store_strb to the first captured sample.
- n_samples  in  ADDR_W  window length in samples.
- rd_start  in  1  pulse that begins readout.
- rd_data  out  WIDTH  readout sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  marks the final sample of the window.
- busy  out  1  high in any state other than IDLE.
- trig_missed  out  1  sticky flag: a store_strb arrived while busy.

Behaviour:
- Reset (asynchronous, active-high) clears all outputs to 0 and forces state IDLE. Buffer contents are undefined after reset.
- A reset asserted mid-capture or mid-readout aborts the operation. No partial stream is resumed afterwards.
- data_out = data_in XOR BITFLIP, registered. Latency is exactly 1 cycle. It runs in every state, including during capture and readout.
- States: IDLE, DELAY, CAPTURE, FULL, READOUT.
- IDLE:
  - store_strb with n_samples != 0 latches len = min(n_samples, DEPTH) and dly = trig_delay.
  - Next state is DELAY if dly != 0, otherwise CAPTURE.
  - store_strb with n_samples == 0 is ignored and does not set trig_missed.
- DELAY: counts dly cycles, then moves to CAPTURE. The first captured sample is the data_out value present dly+1 cycles after the store_strb cycle.
- CAPTURE:
  - Writes data_out to buf[0..len-1], one sample per cycle, with no gaps.
  - On the write to address len-1, moves to FULL.
- FULL: holds the data until rd_start arrives, then moves to READOUT.
- READOUT (AXI-stream rules):
  - Synchronous RAM read; the first rd_valid appears 2 cycles after rd_start.
  - rd_data and rd_last are held stable while rd_valid && !rd_ready.
  - One word is transferred per cycle when rd_ready is held high (no bubbles after the first word).
  - rd_last is high only with word len-1.
  - The handshake of the last word returns the block to IDLE, with rd_valid low on the next cycle.
- rd_start outside FULL is ignored.
- store_strb outside IDLE is ignored and sets trig_missed.
- trig_missed clears on the cycle rd_start is accepted in FULL. If clear and set coincide, set wins.
- store_strb and rd_start arriving in the same cycle are each evaluated against the current state only.
- The address counter never wraps: n_samples > DEPTH is clamped to DEPTH.

Test Plan:
1. Bit-flip correction: BITFLIP=13'h1685, data_in=13'h1685^13'h1F00 → data_out=13'h1F00 (-256) exactly 1 cycle later; data_in=13'h1685 → data_out=0.
2. Delayed capture and readout: ramp data_out=k at cycle k; store_strb at k=10, trig_delay=5, n_samples=8; rd_start with rd_ready=1 → rd_data=16..23, rd_last on 23, busy drops after the last handshake.
3. Zero delay and clamp: trig_delay=0, n_samples=200 (DEPTH=164) → 164 words equal to strobe_cycle+1 onward; rd_last on word 163.
4. Backpressure: during readout, toggle rd_ready 1,0,0,1 → rd_data and rd_last hold while stalled; no word is lost or duplicated (compare against a scoreboard).
5. Missed trigger and ignores: store_strb during CAPTURE → trig_missed=1, buffer unchanged; n_samples=0 strobe → stays IDLE; rd_start in IDLE → no rd_valid; trig_missed clears on the next accepted rd_start.
6. Reset mid-readout: assert rst after 3 words → rd_valid, busy, rd_last and data_out are 0 immediately (asynchronous); after release, the block is IDLE and a new capture runs correctly.

Source files
------------

// File: rtl/adc_chan_capture.sv
// adc_chan_capture: per-channel ADC front end.
// Corrects the board bit-inversion mask and presents signed samples to the core.
// A store strobe captures a delayed window of samples into a buffer,
// which is then streamed out over a valid/ready port.
module adc_chan_capture #(
   parameter int               WIDTH   = 13,
   parameter logic [WIDTH-1:0] BITFLIP = '0,
   parameter int               DEPTH   = 164,
   parameter int               ADDR_W  = 8,
   parameter int               DLY_W   = 7
) (
   input  logic              clk357,
   input  logic              rst,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  data_out,
   input  logic              store_strb,
   input  logic [DLY_W-1:0]  trig_delay,
   input  logic [ADDR_W-1:0] n_samples,
   input  logic              rd_start,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              busy,
   output logic              trig_missed
);

   // One extra bit so a window of exactly 2^ADDR_W samples still fits.
   localparam int               LEN_W   = ADDR_W + 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   typedef enum logic [2:0] {IDLE, DELAY, CAPTURE, FULL, READOUT} state_t;

   state_t             state_q, state_d;
   logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic [LEN_W-1:0]   rptr_q, rptr_d;
   logic               rd_valid_q, rd_valid_d;
   logic               rd_last_q, rd_last_d;
   logic               missed_q, missed_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               mem_we, mem_re;
   logic [LEN_W-1:0]   n_clamped;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [WIDTH-1:0]   mem_rd_q;

   assign n_clamped = ({1'b0, n_samples} > DEPTH_L) ? DEPTH_L : {1'b0, n_samples};

   // Next-state, counters, trigger bookkeeping and readout handshake.
   always_comb begin
      state_d    = state_q;
      dly_cnt_d  = dly_cnt_q;
      len_d      = len_q;
      waddr_d    = waddr_q;
      rptr_d     = rptr_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      dout_d     = data_in ^ BITFLIP;
      mem_we     = 1'b0;
      mem_re     = 1'b0;

      // Clear on accepted rd_start; a coincident missed strobe wins.
      missed_d = missed_q;
      if (state_q == FULL && rd_start) missed_d = 1'b0;
      if (store_strb && state_q != IDLE) missed_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (store_strb && n_samples != '0) begin
               len_d     = n_clamped;
               dly_cnt_d = trig_delay;
               waddr_d   = '0;
               state_d   = (trig_delay != '0) ? DELAY : CAPTURE;
            end
         end
         DELAY: begin
            dly_cnt_d = dly_cnt_q - 1'b1;
            if (dly_cnt_q == DLY_W'(1)) state_d = CAPTURE;
         end
         CAPTURE: begin
            mem_we  = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if ({1'b0, waddr_q} == len_q - 1'b1) state_d = FULL;
         end
         FULL: begin
            if (rd_start) begin
               rptr_d  = '0;
               state_d = READOUT;
            end
         end
         READOUT: begin
            if (rd_valid_q && rd_ready) begin
               rd_valid_d = 1'b0;
               if (rd_last_q) begin
                  rd_last_d = 1'b0;
                  state_d   = IDLE;
               end
            end
            // Fetch the next word whenever the output slot is free or draining.
            if ((!rd_valid_q || rd_ready) && rptr_q < len_q) begin
               mem_re     = 1'b1;
               rd_valid_d = 1'b1;
               rd_last_d  = (rptr_q == len_q - 1'b1);
               rptr_d     = rptr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; reset aborts any capture or stream.
   always_ff @(posedge clk357 or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dly_cnt_q  <= '0;
         len_q      <= '0;
         waddr_q    <= '0;
         rptr_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         missed_q   <= 1'b0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         dly_cnt_q  <= dly_cnt_d;
         len_q      <= len_d;
         waddr_q    <= waddr_d;
         rptr_q     <= rptr_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         missed_q   <= missed_d;
         dout_q     <= dout_d;
      end
   end

   // Sample buffer: plain synchronous RAM, no reset on the array or read port.
   always_ff @(posedge clk357) begin
      if (mem_we) mem[waddr_q] <= dout_q;
      if (mem_re) mem_rd_q <= mem[rptr_q[ADDR_W-1:0]];
   end

   // Read register only changes on a fetch, so data holds while stalled.
   assign rd_data     = rd_valid_q ? mem_rd_q : '0;
   assign rd_valid    = rd_valid_q;
   assign rd_last     = rd_last_q;
   assign data_out    = dout_q;
   assign busy        = (state_q != IDLE);
   assign trig_missed = missed_q;

endmodule

// File: tb/tb_adc_chan_capture.sv
// Testbench for adc_chan_capture: random sample stream, scoreboard of
// expected readout windows derived from the recorded input history.
module tb_adc_chan_capture;
   localparam int          WIDTH  = 13;
   localparam int          DEPTH  = 164;
   localparam int          ADDR_W = 8;
   localparam int          DLY_W  = 7;
   localparam logic [12:0] BF     = 13'h1685;
   localparam int          HMASK  = 32767;

   logic              clk357 = 1'b0;
   logic              rst;
   logic [WIDTH-1:0]  data_in;
   logic [WIDTH-1:0]  data_out;
   logic              store_strb;
   logic [DLY_W-1:0]  trig_delay;
   logic [ADDR_W-1:0] n_samples;
   logic              rd_start;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              rd_last;
   logic              busy;
   logic              trig_missed;

   adc_chan_capture #(
      .WIDTH(WIDTH), .BITFLIP(BF), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DLY_W(DLY_W)
   ) dut (
      .clk357(clk357), .rst(rst), .data_in(data_in), .data_out(data_out),
      .store_strb(store_strb), .trig_delay(trig_delay), .n_samples(n_samples),
      .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .trig_missed(trig_missed)
   );

   always #5 clk357 = ~clk357;

   typedef struct packed {
      logic [12:0] data;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          n_xfer = 0;
   int          cyc = 0;
   int          mode = 0;
   logic [12:0] fix_val = '0;
   logic [12:0] hist [0:HMASK];
   bit          mon_en = 1'b0;
   int          dout_from = 1 << 30;
   bit          stall_q = 1'b0;
   logic [12:0] stall_data;
   logic        stall_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one cycle and drive/record this cycle's ADC input.
   task automatic tick();
      @(posedge clk357);
      #1;
      cyc++;
      case (mode)
         1:       data_in = 13'(cyc + 1) ^ BF;  // data_out ramps: value k in cycle k
         2:       data_in = fix_val;
         default: data_in = 13'($urandom);
      endcase
      hist[cyc & HMASK] = data_in;
   endtask

   task automatic set_ready(input int pat, input int k);
      case (pat)
         0:       rd_ready = 1'b1;
         1:       rd_ready = ((k % 4) == 0 || (k % 4) == 3);
         default: rd_ready = 1'($urandom % 2);
      endcase
   endtask

   task automatic do_reset_pulse();
      rst = 1'b1;
      sb.delete();
      tick();
      tick();
      rst = 1'b0;
      hist[cyc & HMASK] = data_in;
      dout_from = cyc + 2;
   endtask

   // Issue a store strobe and wait until the window must be held in FULL.
   task automatic capture(input int nsamp, input int dly, input bit intrude,
                          output int s, output int len);
      n_samples  = 8'(nsamp);
      trig_delay = 7'(dly);
      store_strb = 1'b1;
      s = cyc;
      tick();
      store_strb = 1'b0;
      len = (nsamp > DEPTH) ? DEPTH : nsamp;
      if (intrude) begin
         repeat (4) tick();
         n_samples  = 8'd7;
         trig_delay = '0;
         store_strb = 1'b1;
         tick();
         store_strb = 1'b0;
      end
      while (cyc < s + dly + len + 2) tick();
      @(negedge clk357);
      chk("busy_full", busy, 1);
      chk("no_valid_full", rd_valid, 0);
      if (intrude) chk("trig_missed_set", trig_missed, 1);
   endtask

   // Expected window: corrected samples starting dly+1 cycles after the strobe.
   task automatic readout(input int s, input int dly, input int len,
                          input int pat, input int abort_n);
      exp_t e;
      int   budget;
      int   k;
      for (int i = 0; i < len; i++) begin
         e.data = hist[(s + dly + i) & HMASK] ^ BF;
         e.last = (i == len - 1);
         sb.push_back(e);
      end
      n_xfer = 0;
      rd_start = 1'b1;
      set_ready(pat, 0);
      tick();
      rd_start = 1'b0;
      set_ready(pat, 1);
      @(negedge clk357);
      chk("valid_lat1", rd_valid, 0);
      chk("trig_missed_clr", trig_missed, 0);
      tick();
      set_ready(pat, 2);
      @(negedge clk357);
      chk("valid_lat2", rd_valid, 1);
      budget = 0;
      k = 3;
      while (budget < 8 * len + 40) begin
         tick();
         budget++;
         if (sb.size() == 0) break;
         if (abort_n > 0 && n_xfer == abort_n) break;
         set_ready(pat, k);
         k++;
      end
      rd_ready = 1'b0;
      if (abort_n > 0 && n_xfer == abort_n) begin
         rst = 1'b1;
         #1;
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rd_last", rd_last, 0);
         chk("rst_data_out", data_out, 0);
         do_reset_pulse();
         @(negedge clk357);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_valid", rd_valid, 0);
      end else if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL readout_timeout: %0d words outstanding, required 0", sb.size());
         do_reset_pulse();
      end else begin
         @(negedge clk357);
         chk("valid_drop", rd_valid, 0);
         chk("busy_drop", busy, 0);
      end
   endtask

   // Monitor: corrected-sample latency, hold-while-stalled, scoreboard pops.
   always @(negedge clk357) begin
      exp_t e;
      if (mon_en && !rst) begin
         if (cyc >= dout_from) chk("data_out", data_out, hist[(cyc - 1) & HMASK] ^ BF);
         if (stall_q) begin
            chk("hold_valid", rd_valid, 1);
            chk("hold_data", rd_data, stall_data);
            chk("hold_last", rd_last, stall_last);
         end
         if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got %0h, none required", rd_data);
            end else begin
               e = sb.pop_front();
               chk("rd_data", rd_data, e.data);
               chk("rd_last", rd_last, e.last);
               n_xfer++;
            end
         end
         stall_q    = rd_valid && !rd_ready;
         stall_data = rd_data;
         stall_last = rd_last;
      end else begin
         stall_q = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, len, ns, dl;
      rst = 1'b1;
      data_in = '0;
      store_strb = 1'b0;
      trig_delay = '0;
      n_samples = '0;
      rd_start = 1'b0;
      rd_ready = 1'b0;
      repeat (3) @(posedge clk357);
      #1;
      chk("rst_data_out", data_out, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_last", rd_last, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_trig_missed", trig_missed, 0);
      rst = 1'b0;
      hist[cyc & HMASK] = data_in;
      dout_from = cyc + 2;
      mon_en = 1'b1;

      // Bit-flip correction, exactly one cycle of latency.
      mode = 2;
      fix_val = BF;
      tick();
      fix_val = BF ^ 13'h1F00;
      tick();
      @(negedge clk357);
      chk("flip_zero", data_out, 0);
      tick();
      @(negedge clk357);
      chk("flip_m256", data_out, 13'h1F00);

      // Ramp, delayed capture of 8 words.
      mode = 1;
      repeat (3) tick();
      capture(8, 5, 1'b0, s, len);
      readout(s, 5, len, 0, 0);

      // Zero delay, window clamped to the buffer depth.
      mode = 0;
      capture(200, 0, 1'b0, s, len);
      readout(s, 0, len, 0, 0);

      // Backpressure 1,0,0,1.
      capture(30, 2, 1'b0, s, len);
      readout(s, 2, len, 1, 0);

      // rd_start in IDLE is ignored.
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      repeat (3) begin
         tick();
         @(negedge clk357);
         chk("idle_no_valid", rd_valid, 0);
         chk("idle_not_busy", busy, 0);
      end
      // Zero-length strobe is ignored and does not flag a miss.
      n_samples = '0;
      trig_delay = 7'd3;
      store_strb = 1'b1;
      tick();
      store_strb = 1'b0;
      tick();
      @(negedge clk357);
      chk("zero_len_idle", busy, 0);
      chk("zero_len_no_miss", trig_missed, 0);

      // Strobe during capture: flagged, buffer keeps the original window.
      capture(40, 0, 1'b1, s, len);
      readout(s, 0, len, 0, 0);

      // Reset after 3 words, then a fresh capture.
      capture(20, 3, 1'b0, s, len);
      readout(s, 3, len, 0, 3);
      capture(12, 1, 1'b0, s, len);
      readout(s, 1, len, 2, 0);

      // Random windows, delays and consumer stalls.
      repeat (5) begin
         ns = 1 + int'($urandom_range(0, 199));
         dl = int'($urandom_range(0, 20));
         capture(ns, dl, 1'b0, s, len);
         readout(s, dl, len, 2, 0);
      end

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
